result_unloader: RTL and testbench
==================================

# result_unloader

Synthesizable readout engine for the matrix-multiplication processor. It runs opposite to the file loader that fills data memory. After the active cores signal completion, it reads the matrix header (i, j, k) from data memory and computes where the result matrix C starts. It then streams the i*k result words out over a valid/ready port, so results leave the FPGA without a testbench reading the memory file port. It sits on the data-memory file port (addr_file/dataout_file) beside the processor.

## Interface
- ADDR_W, 8, data-memory address width
- DATA_W, 16, data-memory word width
- MEM_LAT, 1, cycles from mem_addr/mem_rd_en to valid mem_rdata (1..3)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- core_mask  in  4  cores enabled for this run (bit n = core n); sampled at start
- end_process  in  4  per-core end flags from processor
- mem_addr  out  ADDR_W  data-memory read address
- mem_rd_en  out  1  read strobe, one cycle per word
- mem_rdata  in  DATA_W  data-memory read data
- out_data  out  DATA_W  result word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts when high with out_valid
- out_last  out  1  marks final result word
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high in DONE until next accepted start
- err  out  1  address overflow detected this run
- cycle_count  out  32  processing cycles, start to completion

## Operation
- States: IDLE, WAIT_END, HDR, CALC, STREAM, DONE.
- IDLE/DONE + start: latch core_mask, clear cycle_count/err/done, go WAIT_END. Start in any other state is ignored.
- WAIT_END: cycle_count += 1 every cycle, saturating at 2^32-1. Leave to HDR on the first cycle where (end_process & mask) == mask; that cycle is counted. mask = 0 exits on the first WAIT_END cycle (cycle_count = 1).
- HDR: read addresses 0, 1, 2, serialized (one outstanding read). Capture the low 8 bits as i, j, k.
- CALC (1 cycle):
  - base = 3 + i*j + j*k and n = i*k, computed in 17 bits, no truncation.
  - If base + n > 2^ADDR_W: err = 1, go DONE with no beats.
  - If n = 0: go DONE with no beats.
  - Otherwise go STREAM with addr = base and remaining = n.
- STREAM, per word:
  - Pulse mem_rd_en with mem_addr = addr.
  - MEM_LAT cycles later, register mem_rdata into out_data and assert out_valid.
  - out_last = (remaining == 1).
  - Hold out_data/out_valid/out_last stable until out_ready.
  - On handshake: addr += 1, remaining -= 1. Issue the next read in the same cycle, or go DONE if it was the last word.
- DONE: done = 1, busy = 0. Outputs other than done/err/cycle_count return to 0.

## Timing
- Reset (async assert, sync release):
  - state IDLE.
  - mem_addr, mem_rd_en, out_data, out_valid, out_last, busy, done, err all 0.
  - cycle_count 0.
- Reset mid-run aborts immediately. No partial beat survives; out_valid drops asynchronously.
- start sampled at edge T0: busy = 1 from T0+1; WAIT_END occupies T0+1 onward.
- Header latency: 3*(MEM_LAT+1) cycles, then CALC 1 cycle.
- Stream rate: one word per MEM_LAT+1 cycles when out_ready is held high. First out_valid appears MEM_LAT+1 cycles after STREAM entry.
- out_valid never deasserts without a handshake (except reset).
- mem_rd_en is never high while out_valid is high and out_ready is low.
- end_process changing after the HDR transition is ignored.
- mem_addr holds its last value when mem_rd_en = 0.

## Test plan
- Header 2,3,2; mask 4'b1000; end_process[3] rises 10 cycles after start; out_ready = 1:
  - cycle_count = 10.
  - Reads at addresses 0, 1, 2, then 15, 16, 17, 18.
  - 4 beats carrying memory words 15..18, out_last on beat 4, then done = 1, err = 0.
- Same header, out_ready low for 5 cycles at beat 2:
  - out_data/out_last stable for those 5 cycles.
  - No mem_rd_en while stalled.
  - Remaining beats correct and in order.
- Header 10,10,10 (3 + 300 = 303 > 256) -> err = 1, done = 1, zero beats, no reads beyond address 2.
- Header 4,5,0 -> n = 0: done = 1, err = 0, zero beats. Mask 4'b0000 gives cycle_count = 1.
- rst_n pulsed low during beat 3 of a 2,3,2 run:
  - All outputs 0 immediately, state IDLE.
  - A new start reruns the full sequence correctly.
- start pulsed during STREAM -> ignored, stream completes unchanged. start in DONE -> new run, done cleared next cycle.

Source files
------------

// File: rtl/result_unloader.sv
// result_unloader: after the enabled cores finish, reads the (i, j, k) header
// from data memory, locates result matrix C and streams its i*k words out
// over a valid/ready port.
module result_unloader #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        core_mask,
    input  logic [3:0]        end_process,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_END,
        HDR,
        CALC,
        STREAM,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          mask_q;
    logic [1:0]          hdr_idx_q;
    logic [7:0]          i_q, j_q, k_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_hold_q;
    logic [16:0]         remaining_q;
    logic                first_q;
    logic [MEM_LAT-1:0]  rd_pipe_q;

    logic                rd_outstanding;
    logic                rd_tail;
    logic                handshake;
    logic                ends_met;
    logic [16:0]         base_w;
    logic [16:0]         n_w;
    logic [17:0]         end_w;
    logic                overflow;

    assign rd_outstanding = |rd_pipe_q;
    assign rd_tail        = rd_pipe_q[MEM_LAT-1];
    assign handshake      = out_valid && out_ready;
    assign ends_met       = (end_process & mask_q) == mask_q;

    // Layout is header(3) + A(i*j) + B(j*k) + C(i*k); sum is kept one bit wider
    // so the overflow check cannot wrap.
    assign base_w   = 17'd3 + (17'(i_q) * 17'(j_q)) + (17'(j_q) * 17'(k_q));
    assign n_w      = 17'(i_q) * 17'(k_q);
    assign end_w    = {1'b0, base_w} + {1'b0, n_w};
    assign overflow = end_w > (18'd1 << ADDR_W);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read strobe/address and status decode
    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        mem_addr  = addr_hold_q;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = WAIT_END;
            end
            WAIT_END: begin
                if (ends_met) state_d = HDR;
            end
            HDR: begin
                // One read in flight; the next issues the cycle after capture.
                if (!rd_outstanding) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = ADDR_W'(hdr_idx_q);
                end
                if (rd_tail && hdr_idx_q == 2'd2) state_d = CALC;
            end
            CALC: begin
                if (overflow || n_w == 17'd0) state_d = DONE;
                else                          state_d = STREAM;
            end
            STREAM: begin
                // Next read is issued in the handshake cycle itself to sustain
                // one word per MEM_LAT+1 cycles.
                if (first_q) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = addr_q;
                end else if (handshake) begin
                    if (remaining_q == 17'd1) begin
                        state_d = DONE;
                    end else begin
                        mem_rd_en = 1'b1;
                        mem_addr  = addr_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_d = WAIT_END;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-latency tracker, header capture, address/count bookkeeping and output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe_q   <= '0;
            mask_q      <= '0;
            hdr_idx_q   <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            addr_q      <= '0;
            addr_hold_q <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
        end else begin
            rd_pipe_q[0] <= mem_rd_en;
            for (int unsigned b = 1; b < MEM_LAT; b++) begin
                rd_pipe_q[b] <= rd_pipe_q[b-1];
            end

            if (state_d == DONE && state_q != DONE) begin
                addr_hold_q <= '0;
            end else if (mem_rd_en) begin
                addr_hold_q <= mem_addr;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mask_q      <= core_mask;
                        cycle_count <= '0;
                        err         <= 1'b0;
                        hdr_idx_q   <= '0;
                        first_q     <= 1'b0;
                    end
                end
                WAIT_END: begin
                    if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
                end
                HDR: begin
                    if (rd_tail) begin
                        case (hdr_idx_q)
                            2'd0:    i_q <= mem_rdata[7:0];
                            2'd1:    j_q <= mem_rdata[7:0];
                            default: k_q <= mem_rdata[7:0];
                        endcase
                        hdr_idx_q <= hdr_idx_q + 2'd1;
                    end
                end
                CALC: begin
                    if (overflow) begin
                        err <= 1'b1;
                    end else if (n_w != 17'd0) begin
                        addr_q      <= base_w[ADDR_W-1:0];
                        remaining_q <= n_w;
                        first_q     <= 1'b1;
                    end
                end
                STREAM: begin
                    first_q <= 1'b0;
                    if (handshake) begin
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        out_data    <= '0;
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - 17'd1;
                    end
                    if (rd_tail) begin
                        out_data  <= mem_rdata;
                        out_valid <= 1'b1;
                        out_last  <= (remaining_q == 17'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader with a MEM_LAT=1 memory model.
module tb_result_unloader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [3:0]        core_mask;
    logic [3:0]        end_process;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       cycle_count;

    logic [DATA_W-1:0] mem [0:255];

    logic [ADDR_W-1:0] rd_q[$];
    logic [DATA_W-1:0] beat_q[$];
    logic              last_q[$];
    int                stall_viol;
    int                drop_viol;
    logic              prev_hold;
    logic [DATA_W-1:0] prev_data;

    int n_vec = 0;
    int n_err = 0;

    result_unloader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .core_mask(core_mask),
        .end_process(end_process), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .err(err), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory, one cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Monitor in mid-cycle: reads, beats and protocol violations
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (mem_rd_en) rd_q.push_back(mem_addr);
            if (mem_rd_en && out_valid && !out_ready) stall_viol++;
            if (prev_hold && (!out_valid || out_data !== prev_data)) drop_viol++;
            if (out_valid && out_ready) begin
                beat_q.push_back(out_data);
                last_q.push_back(out_last);
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_hdr(input int i, input int j, input int k);
        mem[0] = 16'(i);
        mem[1] = 16'(j);
        mem[2] = 16'(k);
    endtask

    task automatic start_run(input logic [3:0] mask, input int delay);
        rd_q.delete();
        beat_q.delete();
        last_q.delete();
        stall_viol = 0;
        drop_viol  = 0;
        @(posedge clk); #1;
        core_mask = mask;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (delay > 1) begin
            repeat (delay - 1) @(posedge clk);
            #1;
        end
        end_process = 4'hF;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_timeout", 32'(done), 32'd1);
        end_process = 4'h0;
    endtask

    task automatic wait_beat(input int nb, input string tag);
        int t = 0;
        while (!(beat_q.size() == nb && out_valid) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check(tag, 32'(t < 500), 32'd1);
    endtask

    task automatic check_result(input int base, input int n, input logic exp_err, input int exp_cc);
        check("done", 32'(done), 32'd1);
        check("busy", 32'(busy), 32'd0);
        check("err", 32'(err), 32'(exp_err));
        check("out_valid_idle", 32'(out_valid), 32'd0);
        check("cycle_count", cycle_count, 32'(exp_cc));
        check("stall_rd", 32'(stall_viol), 32'd0);
        check("hold_drop", 32'(drop_viol), 32'd0);
        check("n_reads", 32'(rd_q.size()), 32'(3 + n));
        for (int r = 0; r < rd_q.size() && r < 3 + n; r++) begin
            check("rd_addr", 32'(rd_q[r]), (r < 3) ? 32'(r) : 32'(base + r - 3));
        end
        check("n_beats", 32'(beat_q.size()), 32'(n));
        for (int b = 0; b < beat_q.size() && b < n; b++) begin
            check("beat_data", 32'(beat_q[b]), 32'(16'hA000 + base + b));
            check("beat_last", 32'(last_q[b]), 32'(b == n - 1));
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'(16'hA000 + a);
        rst_n       = 1'b0;
        start       = 1'b0;
        core_mask   = 4'h0;
        end_process = 4'h0;
        out_ready   = 1'b1;
        stall_viol  = 0;
        drop_viol   = 0;
        prev_hold   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_cc", cycle_count, 32'd0);

        // 2,3,2: base 15, n 4; end arrives on the 10th WAIT_END cycle
        set_hdr(2, 3, 2);
        start_run(4'b1000, 10);
        wait_done();
        check_result(15, 4, 1'b0, 10);

        // Same, with beat 2 held off for 5 cycles
        start_run(4'b1000, 10);
        wait_beat(1, "stall_reach");
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(16'hA010));
            check("stall_last", 32'(out_last), 32'd0);
            check("stall_rd_en", 32'(mem_rd_en), 32'd0);
        end
        out_ready = 1'b1;
        wait_done();
        check_result(15, 4, 1'b0, 10);

        // 10,10,10: 303 > 256, overflow
        set_hdr(10, 10, 10);
        start_run(4'b1000, 3);
        wait_done();
        check_result(203, 0, 1'b1, 3);

        // 4,5,0 with empty mask: n = 0, one WAIT_END cycle
        set_hdr(4, 5, 0);
        start_run(4'b0000, 5);
        wait_done();
        check_result(23, 0, 1'b0, 1);

        // Reset asserted while beat 3 is on the port
        set_hdr(2, 3, 2);
        start_run(4'b1000, 10);
        wait_beat(2, "beat3_reach");
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rd_en", 32'(mem_rd_en), 32'd0);
        check("abort_cc", cycle_count, 32'd0);
        end_process = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        start_run(4'b1000, 10);
        wait_done();
        check_result(15, 4, 1'b0, 10);

        // start during STREAM is ignored
        start_run(4'b1000, 10);
        wait_beat(1, "restart_reach");
        core_mask = 4'b0000;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        wait_done();
        check_result(15, 4, 1'b0, 10);

        // start in DONE begins a new run immediately
        rd_q.delete();
        beat_q.delete();
        last_q.delete();
        core_mask   = 4'b1000;
        end_process = 4'b1000;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rerun_done", 32'(done), 32'd0);
        check("rerun_busy", 32'(busy), 32'd1);
        wait_done();
        check_result(15, 4, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
